// File: rtl/mux_seq_pkg.sv
// Shared types and helpers for the mux select sequencer.
package mux_seq_pkg;

    localparam int CH_NUM = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } seq_state_t;

    // Index of the lowest set bit of a channel mask; 0 when the mask is empty.
    function automatic logic [SEL_W-1:0] lowest_set(input logic [CH_NUM-1:0] mask);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_next_ch.sv
// Round-robin successor of a channel index within an enable mask.
// wrap is set when no enabled channel exists above the current index,
// in which case next_idx is the lowest enabled channel.
module mux_next_ch
    import mux_seq_pkg::*;
(
    input  logic [CH_NUM-1:0] mask,
    input  logic [SEL_W-1:0]  cur_idx,
    output logic [SEL_W-1:0]  next_idx,
    output logic              wrap
);

    // Scan downward so the last hit is the nearest enabled channel above cur_idx.
    always_comb begin
        next_idx = lowest_set(mask);
        wrap     = 1'b1;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if ((i > int'(cur_idx)) && mask[i]) begin
                next_idx = SEL_W'(i);
                wrap     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Select sequencer for the 4-to-1 mux: steps through enabled channels in
// round-robin order, holds each for dwell+1 cycles, strobes the last cycle
// of each hold and flags frame completion and empty-mask errors.
module mux_sel_sequencer
    import mux_seq_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [3:0]         ch_en,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         select,
    output logic               sample_stb,
    output logic               frame_done,
    output logic               busy,
    output logic               err_nochan
);

    seq_state_t         state_q, state_d;
    logic [DWELL_W-1:0] counter_q, counter_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [CH_NUM-1:0]  en_q, en_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               stop_pend_q, stop_pend_d;
    logic               err_q, err_d;

    logic               hold_end;
    logic [SEL_W-1:0]   adv_idx;
    logic               adv_wrap;

    mux_next_ch u_next_ch (
        .mask     (en_q),
        .cur_idx  (sel_q),
        .next_idx (adv_idx),
        .wrap     (adv_wrap)
    );

    assign hold_end   = (state_q == DWELL) && (counter_q == dwell_q);
    assign sample_stb = hold_end;
    assign frame_done = hold_end && adv_wrap;
    assign busy       = (state_q == DWELL);
    assign select     = sel_q;
    assign err_nochan = err_q;

    // Next-state logic: start/reload handling, hold counting and channel advance.
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        dwell_d     = dwell_q;
        en_d        = en_q;
        sel_d       = sel_q;
        stop_pend_d = stop_pend_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ch_en != '0) begin
                        en_d        = ch_en;
                        dwell_d     = dwell;
                        sel_d       = lowest_set(ch_en);
                        counter_d   = '0;
                        stop_pend_d = stop;
                        state_d     = DWELL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DWELL: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (hold_end) begin
                    counter_d = '0;
                    if (!adv_wrap) begin
                        sel_d = adv_idx;
                    end else if (stop_pend_q || stop) begin
                        stop_pend_d = 1'b0;
                        state_d     = IDLE;
                    end else if (ch_en == '0) begin
                        err_d       = 1'b1;
                        stop_pend_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        en_d    = ch_en;
                        dwell_d = dwell;
                        sel_d   = lowest_set(ch_en);
                    end
                end else begin
                    counter_d = counter_q + DWELL_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and shadow registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            counter_q   <= '0;
            dwell_q     <= '0;
            en_q        <= '0;
            sel_q       <= '0;
            stop_pend_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            dwell_q     <= dwell_d;
            en_q        <= en_d;
            sel_q       <= sel_d;
            stop_pend_q <= stop_pend_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Self-checking bench for mux_sel_sequencer: a frame-list model compared
// every cycle plus directed scenarios with literal expectations.
module tb_mux_sel_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [3:0] ch_en;
    logic [7:0] dwell;
    logic [1:0] select;
    logic       sample_stb;
    logic       frame_done;
    logic       busy;
    logic       err_nochan;

    int checks = 0;
    int errors = 0;

    mux_sel_sequencer #(.DWELL_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .ch_en      (ch_en),
        .dwell      (dwell),
        .select     (select),
        .sample_stb (sample_stb),
        .frame_done (frame_done),
        .busy       (busy),
        .err_nochan (err_nochan)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: the ordered list of channels in the current frame,
    // position within it, cycles already spent on the current channel.
    int m_list[$];
    int m_idx;
    int m_cnt;
    int m_dwell;
    bit m_run;
    bit m_stoppend;
    bit m_err;
    int m_lastsel;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void buildFrame(input logic [3:0] mask);
        m_list.delete();
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) m_list.push_back(i);
        end
    endfunction

    // Model advances on the same edge as the DUT, from the sampled inputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_list.delete();
            m_idx = 0; m_cnt = 0; m_dwell = 0;
            m_run = 0; m_stoppend = 0; m_err = 0; m_lastsel = 0;
        end else begin
            bit new_err;
            bit stop_now;
            new_err = 0;
            if (!m_run) begin
                if (start) begin
                    if (ch_en != 4'b0000) begin
                        buildFrame(ch_en);
                        m_idx = 0; m_cnt = 0; m_dwell = int'(dwell);
                        m_run = 1; m_stoppend = stop;
                    end else begin
                        new_err = 1;
                    end
                end
            end else begin
                stop_now = m_stoppend || stop;
                if (stop) m_stoppend = 1;
                if (m_cnt == m_dwell) begin
                    m_cnt = 0;
                    if (m_idx < m_list.size() - 1) begin
                        m_idx++;
                    end else if (stop_now) begin
                        m_run = 0; m_stoppend = 0;
                    end else if (ch_en == 4'b0000) begin
                        new_err = 1; m_run = 0; m_stoppend = 0;
                    end else begin
                        buildFrame(ch_en);
                        m_idx = 0; m_dwell = int'(dwell);
                    end
                end else begin
                    m_cnt++;
                end
            end
            if (m_run) m_lastsel = m_list[m_idx];
            m_err = new_err;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            bit e_stb;
            e_stb = m_run && (m_cnt == m_dwell);
            checkOutput("model_select", int'(select), m_lastsel);
            checkOutput("model_busy", int'(busy), int'(m_run));
            checkOutput("model_stb", int'(sample_stb), int'(e_stb));
            checkOutput("model_frame_done", int'(frame_done),
                        int'(e_stb && (m_idx == m_list.size() - 1)));
            checkOutput("model_err", int'(err_nochan), int'(m_err));
        end
    end

    task automatic applyStimulus(input logic s, input logic p, input logic [3:0] m, input logic [7:0] d);
        @(negedge clk);
        #1;
        start = s;
        stop  = p;
        ch_en = m;
        dwell = d;
    endtask

    task automatic pulseStop();
        @(negedge clk);
        #1 stop = 1'b1;
        @(negedge clk);
        #1 stop = 1'b0;
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_timeout", int'(busy), 0);
    endtask

    task automatic waitFrameDone(input int bound);
        int n = 0;
        while (!frame_done && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput("frame_done_timeout", int'(frame_done), 1);
    endtask

    // Watchdog so a stuck run still ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int basic_sel[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
        int stb_count;
        int n;

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; ch_en = 4'b0000; dwell = 8'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_select", int'(select), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_stb", int'(sample_stb), 0);
        checkOutput("rst_frame_done", int'(frame_done), 0);
        checkOutput("rst_err", int'(err_nochan), 0);
        #1 rst_n = 1'b1;

        // Full mask, dwell 2.
        applyStimulus(1'b1, 1'b0, 4'b1111, 8'd2);
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            checkOutput("basic_select", int'(select), basic_sel[k]);
            checkOutput("basic_stb", int'(sample_stb), int'(k % 3 == 2));
            checkOutput("basic_frame_done", int'(frame_done), int'(k == 11));
            checkOutput("basic_busy", int'(busy), 1);
            if (k == 0) #1 start = 1'b0;
        end
        pulseStop();
        waitIdle(40);

        // Sparse mask, dwell 0.
        applyStimulus(1'b1, 1'b0, 4'b1010, 8'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("sparse_select", int'(select), (k % 2 == 1) ? 3 : 1);
            checkOutput("sparse_stb", int'(sample_stb), 1);
            checkOutput("sparse_frame_done", int'(frame_done), int'(k % 2 == 1));
            if (k == 0) #1 start = 1'b0;
        end
        pulseStop();
        waitIdle(20);

        // Single channel, dwell 1.
        applyStimulus(1'b1, 1'b0, 4'b0100, 8'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("single_select", int'(select), 2);
            checkOutput("single_stb", int'(sample_stb), int'(k % 2 == 1));
            checkOutput("single_frame_done", int'(frame_done), int'(k % 2 == 1));
            if (k == 0) #1 start = 1'b0;
        end
        pulseStop();
        waitIdle(20);

        // Start with an empty mask.
        applyStimulus(1'b1, 1'b0, 4'b0000, 8'd0);
        @(negedge clk);
        checkOutput("nochan_err", int'(err_nochan), 1);
        checkOutput("nochan_busy", int'(busy), 0);
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput("nochan_err_clear", int'(err_nochan), 0);
        checkOutput("nochan_busy_after", int'(busy), 0);

        // Mask cleared while running: error at the frame boundary.
        applyStimulus(1'b1, 1'b0, 4'b1111, 8'd0);
        @(negedge clk);
        #1 start = 1'b0;
        ch_en = 4'b0000;
        waitFrameDone(20);
        @(negedge clk);
        checkOutput("reload_err", int'(err_nochan), 1);
        checkOutput("reload_busy", int'(busy), 0);
        checkOutput("reload_select_hold", int'(select), 3);
        @(negedge clk);
        checkOutput("reload_err_clear", int'(err_nochan), 0);

        // Stop mid-frame, dwell 3: the frame still finishes through select 3.
        applyStimulus(1'b1, 1'b0, 4'b1111, 8'd3);
        @(negedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #1 stop = 1'b1;
        @(negedge clk);
        #1 stop = 1'b0;
        waitFrameDone(40);
        checkOutput("stop_last_select", int'(select), 3);
        @(negedge clk);
        checkOutput("stop_busy_drop", int'(busy), 0);
        stb_count = 0;
        repeat (6) begin
            @(negedge clk);
            stb_count += int'(sample_stb);
        end
        checkOutput("stop_no_stb", stb_count, 0);

        // Dwell changed 3 -> 0 mid-frame takes effect only in the next frame.
        applyStimulus(1'b1, 1'b0, 4'b1111, 8'd3);
        stb_count = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k < 16) begin
                stb_count += int'(sample_stb);
                if (k == 15) checkOutput("dwell_old_frame_done", int'(frame_done), 1);
            end else begin
                checkOutput("dwell_new_stb", int'(sample_stb), 1);
                checkOutput("dwell_new_select", int'(select), k - 16);
            end
            if (k == 0) #1 start = 1'b0;
            if (k == 1) #1 dwell = 8'd0;
        end
        checkOutput("dwell_old_stb_count", stb_count, 4);
        pulseStop();
        waitIdle(20);

        // Start while busy is ignored.
        applyStimulus(1'b1, 1'b0, 4'b1111, 8'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("busy_start_select", int'(select), (k / 2) % 4);
            if (k == 0) #1 start = 1'b0;
            if (k == 4) #1 start = 1'b1;
            if (k == 5) #1 start = 1'b0;
        end
        pulseStop();
        waitIdle(20);

        // Asynchronous reset during the select=2 hold.
        applyStimulus(1'b1, 1'b0, 4'b1111, 8'd3);
        @(negedge clk);
        #1 start = 1'b0;
        n = 0;
        while (select != 2'd2 && n < 30) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("arst_pre_select", int'(select), 2);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("arst_select", int'(select), 0);
        checkOutput("arst_busy", int'(busy), 0);
        checkOutput("arst_stb", int'(sample_stb), 0);
        checkOutput("arst_frame_done", int'(frame_done), 0);
        checkOutput("arst_err", int'(err_nochan), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("arst_stays_idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Upstream control stage for the team's 4-to-1 multiplexer.
- Generates the 2-bit select that steps through the enabled inputs a/b/c/d in round-robin order.
- Holds each select value for a programmable dwell time, then pulses a sample strobe so the downstream consumer can capture dout while select is stable.
- Reports frame completion, busy status and configuration errors.

Parameters:
- DWELL_W, 8, width of the dwell counter and the dwell input. The maximum hold is 2^DWELL_W cycles per channel.
- CH_NUM, 4, number of mux inputs. Fixed at 4 and kept in the package; select width is 2.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level-sampled start request; acted on only in IDLE.
- stop  in  1  stop request; sticky until the end of the current frame.
- ch_en  in  4  channel enable mask; bit i enables mux input i (0=a, 1=b, 2=c, 3=d).
- dwell  in  DWELL_W  extra hold cycles per channel.
- select  out  2  mux select, registered.
- sample_stb  out  1  one-cycle strobe in the last cycle of each channel's hold.
- frame_done  out  1  one-cycle pulse coincident with sample_stb of the last enabled channel in a frame.
- busy  out  1  high while sequencing.
- err_nochan  out  1  one-cycle pulse when a start or reload sees ch_en == 0.

Behaviour:
- Reset (async, rst_n=0):
  - select=0, sample_stb=0, frame_done=0, busy=0, err_nochan=0.
  - State IDLE; counter=0; shadow registers=0; stop_pend=0.
- States: IDLE, DWELL.
- IDLE, start=1 and ch_en!=0:
  - Latch ch_en→en_q and dwell→dwell_q.
  - select ← lowest set bit of ch_en; counter ← 0; busy ← 1; go to DWELL.
  - All of these are visible the cycle after start is sampled.
- IDLE, start=1 and ch_en==0: err_nochan pulses for 1 cycle; stay in IDLE; busy stays 0.
- DWELL hold:
  - Each select value is held for exactly dwell_q+1 cycles.
  - sample_stb=1 in the final cycle of the hold.
  - Consequence: dwell_q=0 gives select changing every cycle with sample_stb continuously high.
- DWELL advance: on the sample_stb cycle, the next select is the next set bit of en_q above the current index, wrapping to the lowest set bit. The counter resets to 0.
- Frame boundary:
  - The frame boundary is when the advance wraps (next index <= current index, including the single-enabled-channel case).
  - frame_done=1 in the same cycle as that sample_stb.
  - ch_en and dwell are reloaded into the shadow registers at that edge; mid-frame changes are ignored.
  - If the reloaded ch_en==0: err_nochan pulses, go to IDLE, busy←0, select holds its last value.
- stop:
  - Any cycle with stop=1 while busy sets stop_pend.
  - At the next frame boundary, go to IDLE: busy←0 the following cycle, stop_pend cleared, select holds its last value.
  - A frame is never truncated.
  - stop in IDLE has no effect, except that start and stop asserted together in IDLE run exactly one frame.
- start while busy is ignored and does not restart the frame.
- sample_stb and frame_done are never asserted in IDLE.
- Asynchronous reset mid-frame returns all outputs to their reset values immediately.
- Counter width is DWELL_W. Comparison is counter==dwell_q; the counter never exceeds dwell_q.

Decomposition:
- Package mux_seq_pkg:
  - CH_NUM=4 and SEL_W=2.
  - State enum {IDLE, DWELL}.
  - A function returning the lowest set bit index of a 4-bit mask.
- One sub-module, mux_next_ch (combinational).
  - Inputs: mask and current index.
  - Outputs: next index and a wrap flag.
  - Exhaustively testable on its own.

Test Plan:
- Basic sequence:
  - Stimulus: ch_en=4'b1111, dwell=2, 1-cycle start.
  - Required response: select 0,0,0,1,1,1,2,2,2,3,3,3,0…; sample_stb on every 3rd cycle; frame_done with the select=3 strobe; busy high from the cycle after start.
- Sparse mask:
  - Stimulus: ch_en=4'b1010, dwell=0.
  - Required response: select alternates 1,3,1,3; sample_stb constant 1; frame_done on every select=3 cycle.
- Single channel:
  - Stimulus: ch_en=4'b0100, dwell=1.
  - Required response: select stays at 2; sample_stb and frame_done both high every 2nd cycle.
- No channels enabled:
  - Stimulus: start with ch_en=0 → err_nochan is a 1-cycle pulse and busy stays 0.
  - Stimulus: while running, change ch_en to 0 → err_nochan pulses at the frame boundary and busy drops the next cycle.
- Stop and mid-frame changes:
  - Stimulus: stop pulsed mid-frame with mask 1111, dwell=3.
  - Required response: the frame completes through select=3; busy←0 the cycle after frame_done; no further sample_stb.
  - Stimulus: change dwell from 3 to 0 mid-frame → the old dwell applies until the boundary and the new dwell applies from the next frame.
- Reset and start while busy:
  - Stimulus: rst_n low mid-hold at select=2 → all outputs go to 0 asynchronously.
  - Stimulus: start asserted while busy → no restart and no change to the sequence.
